// File: rtl/alarm_clk_fsm_pkg.sv
// Shared types and constants for the alarm clock control FSM.
// State encoding, default timing constants and a saturating counter helper.
package alarm_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_ENTRY        = 3'd1,
        KEY_STORED       = 3'd2,
        SHOW_ALARM       = 3'd3,
        SET_ALARM_TIME   = 3'd4,
        SET_CURRENT_TIME = 3'd5,
        KEY_WAITED       = 3'd6
    } state_e;

    localparam int TIMEOUT_S_DEF  = 10;
    localparam int NUM_DIGITS_DEF = 4;

    function automatic logic [2:0] sat_inc(input logic [2:0] v,
                                           input logic [2:0] max);
        return (v >= max) ? max : v + 3'd1;
    endfunction

endpackage

// File: rtl/alarm_clk_fsm_if.sv
// Bundle between the alarm clock controller and its surroundings.
// master: keypad/button/tick source; slave: the control FSM.
interface alarm_clk_fsm_if;

    logic       one_second;
    logic       key_valid;
    logic       alarm_button;
    logic       time_button;
    logic       load_new_a;
    logic       load_new_c;
    logic       show_a;
    logic       show_new_time;
    logic       shift;
    logic       clear_keys;
    logic [2:0] digit_count;

    modport master (
        output one_second, key_valid, alarm_button, time_button,
        input  load_new_a, load_new_c, show_a, show_new_time,
        input  shift, clear_keys, digit_count
    );

    modport slave (
        input  one_second, key_valid, alarm_button, time_button,
        output load_new_a, load_new_c, show_a, show_new_time,
        output shift, clear_keys, digit_count
    );

endinterface

// File: rtl/alarm_clk_fsm_timer.sv
// Idle timer for key entry, counting one_second ticks.
// Ports: clk, reset (async low), clear, enable, one_second -> timeout.
module entry_timeout_timer #(
    parameter int TIMEOUT_S = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic one_second,
    output logic timeout
);

    logic [3:0] timer_q;
    logic [3:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = 4'd0;
        end else if (enable && one_second) begin
            timer_d = timer_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= 4'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Fires on the tick that completes TIMEOUT_S idle seconds.
    assign timeout = enable && one_second &&
                     (timer_q == 4'(TIMEOUT_S - 1));

endmodule

// File: rtl/alarm_clk_fsm.sv
// Alarm clock main control FSM: key entry, display select, load pulses.
// Ports: clk, reset (async low), bus (slave modport of alarm_clk_fsm_if).
module alarm_clk_fsm
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_S  = TIMEOUT_S_DEF,
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
    input logic            clk,
    input logic            reset,
    alarm_clk_fsm_if.slave bus
);

    localparam logic [2:0] MAX_DIG = 3'(NUM_DIGITS);

    state_e     state_q, state_d;
    logic [2:0] digit_count_q, digit_count_d;
    logic       in_entry;
    logic       timeout;

    assign in_entry = (state_q == KEY_ENTRY) || (state_q == KEY_WAITED);

    entry_timeout_timer #(
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!in_entry),
        .enable     (in_entry),
        .one_second (bus.one_second),
        .timeout    (timeout)
    );

    always_comb begin
        state_d       = state_q;
        digit_count_d = digit_count_q;
        unique case (state_q)
            SHOW_TIME: begin
                digit_count_d = 3'd0;
                if (bus.alarm_button)   state_d = SHOW_ALARM;
                else if (bus.key_valid) state_d = KEY_STORED;
            end
            KEY_STORED: begin
                digit_count_d = sat_inc(digit_count_q, MAX_DIG);
                state_d       = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (timeout)             state_d = SHOW_TIME;
                else if (!bus.key_valid) state_d = KEY_ENTRY;
            end
            KEY_ENTRY: begin
                // Keys only count until full; buttons only once full.
                if (timeout) begin
                    state_d = SHOW_TIME;
                end else if (digit_count_q < MAX_DIG) begin
                    if (bus.key_valid) state_d = KEY_STORED;
                end else if (bus.alarm_button) begin
                    state_d = SET_ALARM_TIME;
                end else if (bus.time_button) begin
                    state_d = SET_CURRENT_TIME;
                end
            end
            SHOW_ALARM: begin
                if (!bus.alarm_button) state_d = SHOW_TIME;
            end
            SET_ALARM_TIME,
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SHOW_TIME;
            digit_count_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            digit_count_q <= digit_count_d;
        end
    end

    always_comb begin
        bus.load_new_a    = 1'b0;
        bus.load_new_c    = 1'b0;
        bus.show_a        = 1'b0;
        bus.show_new_time = 1'b0;
        bus.shift         = 1'b0;
        bus.clear_keys    = 1'b0;
        unique case (state_q)
            SHOW_TIME:        bus.clear_keys = 1'b1;
            KEY_STORED: begin
                bus.shift         = 1'b1;
                bus.show_new_time = 1'b1;
            end
            KEY_WAITED,
            KEY_ENTRY:        bus.show_new_time = 1'b1;
            SHOW_ALARM:       bus.show_a = 1'b1;
            SET_ALARM_TIME:   bus.load_new_a = 1'b1;
            SET_CURRENT_TIME: bus.load_new_c = 1'b1;
            default:          bus.clear_keys = 1'b1;
        endcase
    end

    assign bus.digit_count = digit_count_q;

endmodule

// File: tb/tb_alarm_clk_fsm.sv
// Self-checking bench for alarm_clk_fsm: directed scenarios then random
// keypad/button/tick traffic compared against a mode-level reference model.
module tb_alarm_clk_fsm;

    localparam int T_S = 10;
    localparam int ND  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_AVIEW = 2;
    localparam int M_LA    = 3;
    localparam int M_LC    = 4;

    logic clk;
    logic reset;

    alarm_clk_fsm_if bus();

    alarm_clk_fsm #(
        .TIMEOUT_S  (T_S),
        .NUM_DIGITS (ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int m_mode;
    int m_digits;
    int m_secs;
    bit m_pend;
    bit m_held;
    int cnt_shift;
    int cnt_la;
    int cnt_lc;
    int cnt_sa;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_digits = 0;
        m_secs   = 0;
        m_pend   = 1'b0;
        m_held   = 1'b0;
    endtask

    // Entry is a single "mode"; a stored key is a pending flag that shows
    // as a shift, and a held key must be released before the next one.
    task automatic model_step(input bit ks, input bit ab,
                              input bit tbn, input bit os);
        bit to;
        case (m_mode)
            M_IDLE: begin
                m_digits = 0;
                m_secs   = 0;
                if (ab) m_mode = M_AVIEW;
                else if (ks) begin
                    m_mode = M_ENTRY;
                    m_pend = 1'b1;
                end
            end
            M_ENTRY: begin
                if (m_pend) begin
                    m_pend = 1'b0;
                    m_held = 1'b1;
                    m_secs = 0;
                    if (m_digits < ND) m_digits++;
                end else begin
                    to = os && (m_secs == T_S - 1);
                    if (os) m_secs++;
                    if (to) m_mode = M_IDLE;
                    else if (m_held) begin
                        if (!ks) m_held = 1'b0;
                    end else if (m_digits < ND) begin
                        if (ks) m_pend = 1'b1;
                    end else if (ab) m_mode = M_LA;
                    else if (tbn) m_mode = M_LC;
                end
            end
            M_AVIEW: begin
                m_secs = 0;
                if (!ab) m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("clear_keys", int'(bus.clear_keys), int'(m_mode == M_IDLE));
        chk("show_a", int'(bus.show_a), int'(m_mode == M_AVIEW));
        chk("load_new_a", int'(bus.load_new_a), int'(m_mode == M_LA));
        chk("load_new_c", int'(bus.load_new_c), int'(m_mode == M_LC));
        chk("show_new_time", int'(bus.show_new_time),
            int'(m_mode == M_ENTRY));
        chk("shift", int'(bus.shift), int'(m_mode == M_ENTRY && m_pend));
        chk("digit_count", int'(bus.digit_count), m_digits);
    endtask

    // One clock: drive after negedge, model at posedge, check #1 later.
    task automatic cyc(input bit ks, input bit ab,
                       input bit tbn, input bit os);
        bus.key_valid    = ks;
        bus.alarm_button = ab;
        bus.time_button  = tbn;
        bus.one_second   = os;
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(ks, ab, tbn, os);
        #1;
        check_all();
        if (bus.shift) cnt_shift++;
        if (bus.load_new_a) cnt_la++;
        if (bus.load_new_c) cnt_lc++;
        if (bus.show_a) cnt_sa++;
        @(negedge clk);
    endtask

    task automatic key(input int hold);
        for (int i = 0; i < hold; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic clr_cnt();
        cnt_shift = 0;
        cnt_la    = 0;
        cnt_lc    = 0;
        cnt_sa    = 0;
    endtask

    initial begin
        bit ks, ab, tbn, os;
        n_vec = 0;
        n_err = 0;
        clr_cnt();
        model_reset();
        reset = 1'b0;
        bus.key_valid    = 1'b0;
        bus.alarm_button = 1'b0;
        bus.time_button  = 1'b0;
        bus.one_second   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);

        // Four digits then time button.
        clr_cnt();
        for (int k = 0; k < 4; k++) key(5);
        chk("digits_full", int'(bus.digit_count), 4);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("n_shift_time", cnt_shift, 4);
        chk("n_load_c", cnt_lc, 1);
        chk("n_load_a_time", cnt_la, 0);

        // Four digits then both buttons; alarm held after.
        clr_cnt();
        for (int k = 0; k < 4; k++) key(5);
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("n_load_a_both", cnt_la, 1);
        chk("n_load_c_both", cnt_lc, 0);

        // Two keys then ten ticks: abort, no load.
        clr_cnt();
        key(3);
        key(3);
        for (int t = 0; t < 10; t++) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
        end
        chk("abort_idle", int'(bus.clear_keys), 1);
        chk("abort_noload", cnt_la + cnt_lc, 0);

        // Nine ticks, a key, nine ticks: no abort.
        key(2);
        for (int t = 0; t < 9; t++) cyc(0, 0, 0, 1);
        key(2);
        for (int t = 0; t < 9; t++) cyc(0, 0, 0, 1);
        chk("restart_entry", int'(bus.show_new_time), 1);
        for (int t = 0; t < 3; t++) cyc(0, 0, 0, 1);

        // Alarm view for 8 cycles with keys pressed meanwhile.
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);
        clr_cnt();
        for (int i = 0; i < 8; i++) cyc(i >= 2 && i < 6, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        chk("n_show_a", cnt_sa, 8);
        chk("n_shift_alarm", cnt_shift, 0);

        // Three digits, time button ignored, then async reset.
        for (int k = 0; k < 3; k++) key(2);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("partial_stay", int'(bus.show_new_time), 1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        cyc(1, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0);

        // Random traffic.
        ks = 0;
        ab = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(5) == 0) ks = ~ks;
            if ($urandom_range(19) == 0) ab = ~ab;
            tbn = ($urandom_range(7) == 0);
            os  = ($urandom_range(2) == 0);
            cyc(ks, ab, tbn, os);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_clk_fsm.md
Name: alarm_clk_fsm

Overview:
Main control FSM of the alarm clock. It sequences keypad entry into the key shift register and shows the entered digits. On the time button it issues the one-cycle load_new_c to the time counter; on the alarm button it issues load_new_a to the alarm register. It also drives display selection and aborts entry after an idle timeout counted in one_second ticks.

Parameters:
TIMEOUT_S, 10, idle seconds in key entry before abort to SHOW_TIME (legal 2..15)
NUM_DIGITS, 4, digits required before a load is accepted

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
one_second  in  1  single-cycle pulse once per second
key_valid  in  1  keypad digit pressed (already synchronised/debounced); level while held
alarm_button  in  1  alarm button level
time_button  in  1  time button level
load_new_a  out  1  one-cycle pulse: alarm register loads key register
load_new_c  out  1  one-cycle pulse: time counter loads key register
show_a  out  1  display alarm time
show_new_time  out  1  display key register instead of current time
shift  out  1  one-cycle pulse: key register shifts in current key
clear_keys  out  1  hold key register cleared
digit_count  out  3  digits entered so far, 0..NUM_DIGITS

Behaviour:
- Reset (reset=0, async): state=SHOW_TIME, timer=0, digit_count=0.
- Reset values of outputs: all 0 except clear_keys=1.
- Outputs are Moore, decoded from the state register only. A load pulse is high exactly in the single cycle the FSM spends in SET_* state.
- States and outputs:
  - SHOW_TIME: clear_keys=1
  - KEY_STORED: shift=1, show_new_time=1
  - KEY_WAITED: show_new_time=1
  - KEY_ENTRY: show_new_time=1
  - SHOW_ALARM: show_a=1
  - SET_ALARM_TIME: load_new_a=1
  - SET_CURRENT_TIME: load_new_c=1
- Transitions, first match wins:
  - SHOW_TIME: alarm_button -> SHOW_ALARM; key_valid -> KEY_STORED; else stay.
  - KEY_STORED: always -> KEY_WAITED (one cycle). digit_count increments, saturating at NUM_DIGITS.
  - KEY_WAITED: timeout -> SHOW_TIME; !key_valid -> KEY_ENTRY; else stay. A held key yields exactly one shift.
  - KEY_ENTRY: timeout -> SHOW_TIME; key_valid and digit_count<NUM_DIGITS -> KEY_STORED.
    - With digit_count==NUM_DIGITS: alarm_button -> SET_ALARM_TIME; else time_button -> SET_CURRENT_TIME.
    - Keys pressed with digit_count==NUM_DIGITS are ignored.
    - Buttons pressed with digit_count<NUM_DIGITS are ignored.
  - SHOW_ALARM: !alarm_button -> SHOW_TIME; else stay. Keys are ignored.
  - SET_ALARM_TIME and SET_CURRENT_TIME: always -> SHOW_TIME.
- Simultaneous alarm_button and time_button in KEY_ENTRY: alarm wins.
- Timer (width 4):
  - Cleared in every state other than KEY_ENTRY/KEY_WAITED, and on entry to KEY_STORED.
  - In KEY_ENTRY/KEY_WAITED it increments on one_second.
  - timeout = one_second && timer==TIMEOUT_S-1, so the abort takes TIMEOUT_S full ticks after the last key.
- digit_count clears in SHOW_TIME; unchanged elsewhere except KEY_STORED.
- Reset asserted mid-entry: immediate return to the reset values above. No load pulse is produced.
- Exit from SET_*: returns to SHOW_TIME, so clear_keys reasserts the cycle after a load pulse. The loaded value is sampled by the consumer on the pulse edge.

Decomposition:
- Shared package alarm_pkg:
  - state enum, 3-bit encoding: SHOW_TIME=0, KEY_ENTRY=1, KEY_STORED=2, SHOW_ALARM=3, SET_ALARM_TIME=4, SET_CURRENT_TIME=5, KEY_WAITED=6
  - default TIMEOUT_S and NUM_DIGITS constants
- Sub-module entry_timeout_timer: one_second counter with clear, enable and timeout output. Everything else stays inline.

Test Plan:
- Reset=0 then release, idle 20 cycles -> clear_keys=1, all other outputs 0, digit_count=0.
- Keys 1,2,3,4 each held 5 cycles then time_button 1 cycle -> exactly 4 shift pulses; digit_count=4; load_new_c=1 for exactly one cycle; then SHOW_TIME with clear_keys=1.
- Same 4 keys, alarm_button and time_button together -> load_new_a pulses once, load_new_c stays 0. Alarm held afterward keeps SHOW_TIME, not SHOW_ALARM, until the next cycle of evaluation.
- Two keys then 10 one_second pulses -> return to SHOW_TIME on the 10th tick, no load pulse. With 9 pulses then a key, the timer restarts and there is no abort.
- In SHOW_TIME, alarm_button held 8 cycles -> show_a=1 for exactly those cycles; key_valid during that time gives no shift.
- Three keys entered, then time_button -> ignored, stays KEY_ENTRY. Assert reset mid-entry -> state SHOW_TIME, digit_count=0 asynchronously.
